// File: rtl/i2c_uart_bridge_ctrl_pkg.sv
// Shared definitions for the I2C-to-UART bridge: FSM encoding, ASCII line-ending bytes
// and the UART busy handshake timeout.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        CR,
        LF
    } state_t;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam int         BUSY_TIMEOUT = 4;

endpackage

// File: rtl/i2c_uart_bridge_ctrl_if.sv
// Bus bundle between the I2C slave / UART pair and the bridge sequencer.
// The slave modport is the bridge side; the master modport is the environment side.
interface i2c_uart_bridge_ctrl_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          i_byte_valid;
    logic [7:0]                    i_byte;
    logic                          i_stop_det;
    logic                          i_tx_busy;
    logic                          i_clr_ovf;
    logic [7:0]                    o_tx_data;
    logic                          o_tx_start;
    logic                          o_overflow;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;
    logic                          o_idle;

    modport master (
        output i_byte_valid, i_byte, i_stop_det, i_tx_busy, i_clr_ovf,
        input  o_tx_data, o_tx_start, o_overflow, o_fifo_level, o_idle
    );

    modport slave (
        input  i_byte_valid, i_byte, i_stop_det, i_tx_busy, i_clr_ovf,
        output o_tx_data, o_tx_start, o_overflow, o_fifo_level, o_idle
    );
endinterface

// File: rtl/i2c_uart_bridge_ctrl_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector that emits a single-cycle pulse in the clk domain.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2c_uart_bridge_ctrl.sv
// Bridge sequencer: synchronizes I2C byte/STOP events, queues bytes in an inline FIFO and
// paces one UART start per byte. Define BRIDGE_CRLF_EN to append CR/LF after each STOP.
module i2c_uart_bridge_ctrl
    import bridge_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                   i_CLK,
    input logic                   i_RST_N,
    i2c_uart_bridge_ctrl_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;

    logic          byte_evt, stop_evt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, level_q;
    logic          full, empty, push, pop, drop;
    logic          launch, tx_start_q, overflow_q, tmo_hit, tx_done;
    logic [7:0]    launch_data, tx_data_q;
    logic [2:0]    tmo_cnt;
    state_t        state, state_nx, ret_state;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_byte (
        .clk(i_CLK), .rst_n(i_RST_N), .level(bus.i_byte_valid), .pulse(byte_evt)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
        .clk(i_CLK), .rst_n(i_RST_N), .level(bus.i_stop_det), .pulse(stop_evt)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = byte_evt && (!full || pop);
    assign drop  = byte_evt && full && !pop;

    // NOTE: the storage array has no reset; resetting the pointers already empties
    // the FIFO, and a reset on the array would prevent a plain RAM mapping.
    always_ff @(posedge i_CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.i_byte;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push);
            rd_ptr  <= rd_ptr + PW'(pop);
            level_q <= (wr_ptr + PW'(push)) - (rd_ptr + PW'(pop));
            if (drop)               overflow_q <= 1'b1;
            else if (bus.i_clr_ovf) overflow_q <= 1'b0;
        end
    end

    assign tmo_hit = (state == WAIT_BUSY) && !bus.i_tx_busy
                     && (tmo_cnt == 3'(BUSY_TIMEOUT - 1));
    assign tx_done = tmo_hit || ((state == WAIT_DONE) && !bus.i_tx_busy);

`ifdef BRIDGE_CRLF_EN
    logic       pending_q;
    logic [1:0] step_q;

    // step_q: 0 = no line ending in flight, 1 = CR launched, 2 = LF launched.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            pending_q <= 1'b0;
            step_q    <= 2'd0;
        end else begin
            if (stop_evt && !pending_q)          pending_q <= 1'b1;
            else if (tx_done && step_q == 2'd2)  pending_q <= 1'b0;
            if (state == CR && launch)           step_q <= 2'd1;
            else if (state == LF && launch)      step_q <= 2'd2;
            else if (tx_done && step_q == 2'd2)  step_q <= 2'd0;
        end
    end

    assign ret_state = (step_q == 2'd1) ? LF : IDLE;
`else
    logic unused_stop;
    assign unused_stop = stop_evt;
    assign ret_state   = IDLE;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_nx;
            tmo_cnt    <= (state == WAIT_BUSY) ? tmo_cnt + 3'd1 : 3'd0;
            tx_start_q <= launch;
            if (launch) tx_data_q <= launch_data;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!bus.i_tx_busy) begin
                    if (!empty)         state_nx = WAIT_BUSY;
`ifdef BRIDGE_CRLF_EN
                    else if (pending_q) state_nx = CR;
`endif
                end
            end
            WAIT_BUSY: begin
                if (bus.i_tx_busy) state_nx = WAIT_DONE;
                else if (tmo_hit)  state_nx = ret_state;
            end
            WAIT_DONE: if (tx_done) state_nx = ret_state;
`ifdef BRIDGE_CRLF_EN
            CR, LF:    if (!bus.i_tx_busy) state_nx = WAIT_BUSY;
`endif
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        launch      = 1'b0;
        launch_data = mem[rd_ptr[AW-1:0]];
        case (state)
            IDLE: if (!bus.i_tx_busy && !empty) begin
                pop    = 1'b1;
                launch = 1'b1;
            end
`ifdef BRIDGE_CRLF_EN
            CR: if (!bus.i_tx_busy) begin
                launch      = 1'b1;
                launch_data = ASCII_CR;
            end
            LF: if (!bus.i_tx_busy) begin
                launch      = 1'b1;
                launch_data = ASCII_LF;
            end
`endif
            default: ;
        endcase
    end

    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_fifo_level = level_q;
    assign bus.o_idle       = (state == IDLE) && empty;

endmodule

// File: tb/tb_i2c_uart_bridge_ctrl.sv
// Scoreboard bench for i2c_uart_bridge_ctrl: expected UART bytes are queued as stimulus is
// issued, and a monitor compares them against every o_tx_start pulse.
module tb_i2c_uart_bridge_ctrl;
    localparam int FIFO_DEPTH  = 8;
    localparam int SYNC_STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_uart_bridge_ctrl_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    logic hold_busy = 1'b0;
    logic auto_uart = 1'b1;
    int   model_cnt = 0;
    assign bus.i_tx_busy = hold_busy | (model_cnt != 0);

    i2c_uart_bridge_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_CLK(clk),
        .i_RST_N(rst_n),
        .bus(bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         start_count = 0;
    int         s0;
    int         n;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART model: raises busy half a cycle after each start and holds it four cycles.
    always @(negedge clk) begin
        if (bus.o_tx_start && auto_uart) model_cnt = 4;
        else if (model_cnt > 0)          model_cnt = model_cnt - 1;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && bus.o_tx_start) begin
            start_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_start: got tx_data %02h, expected no start", bus.o_tx_data);
            end else begin
                check("tx_data", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic raise_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
    endtask

    task automatic drop_byte();
        repeat (3) @(negedge clk);
        bus.i_byte_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        raise_byte(b);
        drop_byte();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        @(negedge clk);
        while (!bus.o_idle && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.o_idle), 32'd1);
    endtask

    task automatic wait_start(input string name, input int budget);
        int k = 0;
        @(negedge clk);
        while (!bus.o_tx_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.o_tx_start), 32'd1);
    endtask

    task automatic wait_level(input string name, input int value, input int budget);
        int k = 0;
        @(negedge clk);
        while (32'(bus.o_fifo_level) != value && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.o_fifo_level), 32'(value));
    endtask

    task automatic count_to_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_idle && k < 20);
        check(name, 32'(k), 32'(4));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_stop_det   = 1'b0;
        bus.i_clr_ovf    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_data",  32'(bus.o_tx_data),    32'h0);
        check("rst_tx_start", 32'(bus.o_tx_start),   32'h0);
        check("rst_overflow", 32'(bus.o_overflow),   32'h0);
        check("rst_level",    32'(bus.o_fifo_level), 32'h0);
        check("rst_idle",     32'(bus.o_idle),       32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte with an idle UART.
        s0 = start_count;
        exp_q.push_back(8'hA5);
        raise_byte(8'hA5);
        wait_level("single_level_1", 1, 10);
        drop_byte();
        wait_idle("single_idle", 40);
        check("single_level_0", 32'(bus.o_fifo_level), 32'h0);
        check("single_starts",  32'(start_count - s0), 32'd1);

        // Burst while the UART is held busy.
        hold_busy = 1'b1;
        s0 = start_count;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i));
        end
        check("burst_level",     32'(bus.o_fifo_level), 32'd5);
        check("burst_no_starts", 32'(start_count - s0), 32'd0);
        check("burst_not_idle",  32'(bus.o_idle),       32'd0);
        hold_busy = 1'b0;
        wait_idle("burst_idle", 300);
        check("burst_starts", 32'(start_count - s0), 32'd5);
        check("burst_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: the ninth byte into a full FIFO is dropped.
        hold_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_byte(8'h10 + 8'(i));
        end
        check("full_overflow_0", 32'(bus.o_overflow),   32'd0);
        check("full_level",      32'(bus.o_fifo_level), 32'd8);
        send_byte(8'h18);
        check("ovf_set",   32'(bus.o_overflow),   32'd1);
        check("ovf_level", 32'(bus.o_fifo_level), 32'd8);
        @(negedge clk);
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.o_overflow), 32'd0);
        hold_busy = 1'b0;
        wait_idle("ovf_idle", 400);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Busy never rises: timeout returns the FSM to IDLE after four cycles.
        auto_uart = 1'b0;
        exp_q.push_back(8'h5A);
        raise_byte(8'h5A);
        wait_start("tmo_start_1", 20);
        count_to_idle("tmo_cycles_1");
        drop_byte();
        exp_q.push_back(8'h6B);
        raise_byte(8'h6B);
        wait_start("tmo_start_2", 20);
        count_to_idle("tmo_cycles_2");
        drop_byte();
        auto_uart = 1'b1;

        // Reset while in WAIT_DONE with three bytes queued.
        exp_q.push_back(8'h31);
        raise_byte(8'h31);
        wait_start("rstmid_start", 20);
        hold_busy = 1'b1;
        drop_byte();
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h34);
        check("rstmid_level", 32'(bus.o_fifo_level), 32'd3);
        check("rstmid_busy",  32'(bus.o_idle),       32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx_data",  32'(bus.o_tx_data),    32'h0);
        check("rstmid_tx_start", 32'(bus.o_tx_start),   32'h0);
        check("rstmid_overflow", 32'(bus.o_overflow),   32'h0);
        check("rstmid_level_0",  32'(bus.o_fifo_level), 32'h0);
        check("rstmid_idle",     32'(bus.o_idle),       32'h1);
        hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = start_count;
        repeat (40) @(negedge clk);
        check("rstmid_no_starts", 32'(start_count - s0), 32'd0);

        // STOP after two bytes: CR/LF appended only when the feature is built in.
        s0 = start_count;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
`ifdef BRIDGE_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        n = 4;
`else
        n = 2;
`endif
        send_byte(8'h48);
        send_byte(8'h49);
        @(negedge clk);
        bus.i_stop_det = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_stop_det = 1'b0;
        repeat (150) @(negedge clk);
        check("stop_starts",  32'(start_count - s0), 32'(n));
        check("stop_drained", 32'(exp_q.size()),     32'd0);
        check("stop_idle",    32'(bus.o_idle),       32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_uart_bridge_ctrl.md
Name: i2c_uart_bridge_ctrl

Overview:
- Sequencer between the I2C slave receive path and the UART transmitter.
- Brings byte-complete and STOP events from the SCL domain into the system clock domain and buffers received bytes in a small FIFO.
- Issues one UART transmit request per byte, paced by the UART busy flag, and reports overflow status.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops per asynchronous input; minimum 2.

Ports:
- i_CLK  in  1  system clock.
- i_RST_N  in  1  asynchronous active-low reset.
- i_byte_valid  in  1  asynchronous level from the I2C slave, high during the ACK bit of a data byte.
- i_byte  in  8  received byte; stable while i_byte_valid is high and for one SCL period after.
- i_stop_det  in  1  asynchronous STOP indication from the I2C slave.
- i_tx_busy  in  1  UART transmitter busy.
- i_clr_ovf  in  1  synchronous clear of o_overflow.
- o_tx_data  out  8  byte presented to the UART.
- o_tx_start  out  1  one-cycle transmit request.
- o_overflow  out  1  sticky flag: a byte was dropped.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_idle  out  1  high when the FSM is in IDLE and the FIFO is empty.

Behaviour:
- Reset values, applied asynchronously on i_RST_N low:
  - o_tx_data=0, o_tx_start=0, o_overflow=0, o_fifo_level=0, o_idle=1.
  - FIFO pointers 0, FSM=IDLE, synchronizers all 0.
- Input synchronization:
  - i_byte_valid and i_stop_det each pass through SYNC_STAGES flops plus a rising-edge detector, producing 1-cycle pulses byte_evt and stop_evt.
  - On byte_evt, i_byte is sampled directly. It is stable, since the synced edge arrives well inside the hold window (SCL much slower than i_CLK, at least 8x).
- Push: byte_evt writes i_byte at wr_ptr.
  - Accepted when the FIFO is not full, or when it is full and a pop occurs the same cycle.
  - Otherwise the byte is dropped, o_overflow is set to 1, and level is unchanged.
- Pointers: $clog2(FIFO_DEPTH)+1 bits each, wrapping naturally. Full when the MSBs differ and the rest are equal; empty when equal.
- o_fifo_level = wr_ptr - rd_ptr, registered and updated the same cycle as the push/pop.
- Overflow clear: i_clr_ovf clears o_overflow. If a drop occurs in the same cycle, set wins.
- FSM states:
  - IDLE: if the FIFO is non-empty and i_tx_busy=0, then pop, load o_tx_data from the head, assert o_tx_start for 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for i_tx_busy=1, then go to WAIT_DONE. If 4 cycles pass without busy, return to IDLE; the byte counts as sent.
  - WAIT_DONE: on i_tx_busy=0, go to IDLE.
- Latency: first o_tx_start occurs SYNC_STAGES+2 cycles after i_byte_valid rises, if the UART is idle.
- Back-to-back: minimum 2 cycles between o_tx_start pulses (IDLE re-entry).
- o_tx_data holds its value until the next load.
- stop_evt: no effect on the data path unless the optional feature is enabled. Bytes already queued still drain.
- Reset mid-operation: FIFO contents are discarded and any pending transmit is abandoned. o_tx_start is never left high.

Optional Feature:
- Macro: BRIDGE_CRLF_EN.
- Enabled:
  - stop_evt sets a pending flag; a second stop_evt while the flag is pending is ignored.
  - Once the FIFO is empty and the FSM is in IDLE, the FSM sends 0x0D then 0x0A through states CR and LF, each using the same start/WAIT_BUSY/WAIT_DONE handshake, then clears the flag.
  - Bytes arriving during CR/LF are queued normally and are sent after LF.
- Disabled: stop_evt is ignored; no CR/LF states exist.

Decomposition:
- Package bridge_pkg holds:
  - FSM state encoding (IDLE, WAIT_BUSY, WAIT_DONE, CR, LF).
  - Constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - BUSY_TIMEOUT=4.
- One sub-module: sync_edge_detect (parameter SYNC_STAGES; async level in, 1-cycle rising-edge pulse out), instantiated twice.
- The FIFO stays inline.

Test Plan:
- Single byte: pulse i_byte_valid with i_byte=8'hA5, UART idle -> one o_tx_start with o_tx_data=8'hA5; o_fifo_level goes 1 then 0; o_idle returns to 1.
- Burst, slow UART: 5 bytes 8'h01..8'h05 while i_tx_busy is held high -> o_fifo_level=5; after busy drops, 5 starts in order 01..05, each after busy high→low.
- Overflow: 9 bytes with FIFO_DEPTH=8 and busy held high -> byte 9 dropped, o_overflow=1, level=8; i_clr_ovf pulse -> o_overflow=0.
- Busy timeout: i_tx_busy never rises after a start -> FSM back in IDLE after 4 cycles; the next byte is started.
- Reset mid-burst: assert i_RST_N low with 3 bytes queued during WAIT_DONE -> all outputs at reset values immediately; no further o_tx_start after release.
- BRIDGE_CRLF_EN: bytes 8'h48, 8'h49 then i_stop_det -> transmitted sequence 48, 49, 0D, 0A; without the macro, only 48, 49.
